// File: rtl/ram_dist_sp.sv
// Single-port distributed RAM, DATA_W x DEPTH, synchronous write with asynchronous read, plus a reset-driven clear sweep.
// Defining RAM_DIST_SP_OREG_EN adds a read-first output register, which gives a 1-cycle read latency.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_READY | normal operation, writes to A < DEPTH are accepted
//   ST_CLEAR | sweeping CLR_VAL into mem[cnt]; BUSY=1, user writes dropped
module ram_dist_sp #(
  parameter int                          DATA_W     = 8,
  parameter int                          DEPTH      = 64,
  parameter int                          ADDR_W     = 6,
  parameter logic [DATA_W*DEPTH-1:0]     INIT       = '0,
  parameter int                          CLR_ON_RST = 1,
  parameter logic [DATA_W-1:0]           CLR_VAL    = '0
) (
  input  logic              WCLK,
  input  logic              RST_N,
  input  logic              WE,
  input  logic [ADDR_W-1:0] A,
  input  logic [DATA_W-1:0] D,
  output logic [DATA_W-1:0] O,
  output logic              BUSY
);

  typedef enum logic {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // Power-up values come from the declarations; reset deliberately leaves mem alone.
  state_t                  state_q = ST_READY;
  state_t                  state_d;
  logic [ADDR_W-1:0]       cnt_q = '0;
  logic [ADDR_W-1:0]       cnt_d;
  logic [DATA_W*DEPTH-1:0] mem_q = INIT;
  logic [DATA_W*DEPTH-1:0] mem_d;

  logic                    a_in_range;
  logic [DATA_W-1:0]       rd_word;

  assign a_in_range = ({1'b0, A} < DEPTH_CMP);

  always_comb begin
    rd_word = '0;
    if (a_in_range) begin
      rd_word = mem_q[int'(A)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    if (RST_N) begin
      case (state_q)
        ST_CLEAR: begin
          mem_d[int'(cnt_q)*DATA_W +: DATA_W] = CLR_VAL;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR) begin
            state_d = ST_READY;
          end
        end
        default: begin
          if (WE && a_in_range) begin
            mem_d[int'(A)*DATA_W +: DATA_W] = D;
          end
        end
      endcase
    end
  end

  always_ff @(posedge WCLK) begin
    if (!RST_N) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign BUSY = (state_q == ST_CLEAR);

`ifdef RAM_DIST_SP_OREG_EN
  logic [DATA_W-1:0] oreg_q = '0;
  logic [DATA_W-1:0] oreg_d;

  // rd_word is taken from mem_q, so a write edge captures the pre-write word.
  always_comb begin
    oreg_d = rd_word;
  end

  always_ff @(posedge WCLK) begin
    if (!RST_N) begin
      oreg_q <= '0;
    end else begin
      oreg_q <= oreg_d;
    end
  end

  assign O = oreg_q;
`else
  assign O = rd_word;
`endif

endmodule

// File: tb/tb_ram_dist_sp.sv
// Directed bench for ram_dist_sp: one instance with the clear sweep enabled and one without.
module tb_ram_dist_sp;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 48;
  localparam int ADDR_W = 6;

  function automatic logic [DATA_W*DEPTH-1:0] mk_init();
    logic [DATA_W*DEPTH-1:0] r;
    r = '0;
    for (int k = 0; k < DEPTH; k++) r[k*DATA_W +: DATA_W] = 8'(k);
    return r;
  endfunction

  localparam logic [DATA_W*DEPTH-1:0] INIT_V = mk_init();

  logic              clk = 1'b0;
  logic              rst_n_c, rst_n_k, we;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] o_c, o_k;
  logic              busy_c, busy_k;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_dist_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT(INIT_V),
                .CLR_ON_RST(1), .CLR_VAL(8'h3C)) u_clr (
    .WCLK(clk), .RST_N(rst_n_c), .WE(we), .A(a), .D(d), .O(o_c), .BUSY(busy_c));

  ram_dist_sp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT(INIT_V),
                .CLR_ON_RST(0), .CLR_VAL(8'h3C)) u_keep (
    .WCLK(clk), .RST_N(rst_n_k), .WE(we), .A(a), .D(d), .O(o_k), .BUSY(busy_k));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Counts edges until BUSY drops, with a hard bound so a stuck sweep cannot hang the run.
  task automatic count_busy(output int n);
    n = 0;
    while (busy_c === 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    rst_n_c = 1'b1; rst_n_k = 1'b1; we = 1'b0; a = '0; d = '0;
    #1;

    // Power-up contents, no reset applied
    a = 6'd5; tick();
    check("pwrup_o_c", o_c, 8'h05);
    check("pwrup_busy_c", busy_c, 1'b0);
    check("pwrup_o_k", o_k, 8'h05);
    check("pwrup_busy_k", busy_k, 1'b0);

    // Plain write then read-back
    we = 1'b1; a = 6'd3; d = 8'hA5; tick();
    we = 1'b0; tick();
    check("wr_rd_a3", o_c, 8'hA5);
    a = 6'd4; tick();
    check("rd_a4", o_c, 8'h04);

    // Out-of-range write must not alias onto a lower word
    we = 1'b1; a = 6'd50; d = 8'hFF; tick();
    we = 1'b0; tick();
    check("oor_rd_a50", o_c, 8'h00);
    a = 6'd2;  tick(); check("alias_a2", o_c, 8'h02);
    a = 6'd18; tick(); check("alias_a18", o_c, 8'h12);
    a = 6'd47; tick(); check("last_a47", o_c, 8'h2F);

    // Reset without the clear sweep keeps contents
    we = 1'b1; a = 6'd7; d = 8'h77; tick();
    we = 1'b0; rst_n_k = 1'b0; tick();
    check("keep_busy_rst", busy_k, 1'b0);
`ifdef RAM_DIST_SP_OREG_EN
    check("keep_o_rst_edge", o_k, 8'h00);
`else
    check("keep_o_rst_edge", o_k, 8'h77);
`endif
    rst_n_k = 1'b1; tick();
    check("keep_o_after", o_k, 8'h77);
    check("keep_busy_after", busy_k, 1'b0);

    // Clear sweep: reset held two edges, then exactly DEPTH busy edges
    rst_n_c = 1'b0; tick();
    check("clr_busy_rst1", busy_c, 1'b1);
    tick();
    check("clr_busy_rst2", busy_c, 1'b1);
    rst_n_c = 1'b1;
    count_busy(n);
    check("clr_busy_len", n, 48);
    for (int i = 0; i < DEPTH; i++) begin
      a = 6'(i); tick();
      check($sformatf("clr_rd_a%0d", i), o_c, 8'h3C);
    end

    // Mid-sweep reset pulse with WE held high: sweep restarts, writes dropped
    we = 1'b1; d = 8'hD1; a = 6'd10;
    rst_n_c = 1'b0; tick();
    rst_n_c = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("mid_busy_e20", busy_c, 1'b1);
    rst_n_c = 1'b0; tick();
    rst_n_c = 1'b1;
    count_busy(n);
    we = 1'b0;
    check("mid_busy_len", n, 48);
    tick();
    check("mid_rd_a10", o_c, 8'h3C);
    a = 6'd0;  tick(); check("mid_rd_a0", o_c, 8'h3C);
    a = 6'd47; tick(); check("mid_rd_a47", o_c, 8'h3C);

    // Normal write works again after the sweep
    we = 1'b1; a = 6'd47; d = 8'h5A; tick();
    we = 1'b0; tick();
    check("post_wr_a47", o_c, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
